// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and flag bit positions for alu_seq.
package alu_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned FLAGS_W  = 3;

  localparam logic [OPCODE_W-1:0] OP_ORR   = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_ANDR  = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_XORR  = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_AND   = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_OR    = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_XOR   = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_GT    = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_LT    = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_NOT   = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_EQ    = 4'd9;
  localparam logic [OPCODE_W-1:0] OP_ADD   = 4'd10;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 4'd11;
  localparam logic [OPCODE_W-1:0] OP_MUL   = 4'd12;
  localparam logic [OPCODE_W-1:0] OP_SHR   = 4'd13;
  localparam logic [OPCODE_W-1:0] OP_SHL   = 4'd14;
  localparam logic [OPCODE_W-1:0] OP_NOT2  = 4'd15;

  // Bit positions inside flags = {neg, carry, zero}
  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_NEG   = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// WIDTH-step shift-add multiplier. done_c/product_c are combinational so the
// caller can register the final product on the same edge as the last step.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done_c,
  output logic [2*WIDTH-1:0]   product_c
);

  localparam int unsigned CNTW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH:0]     sum_c;

  // prod holds {partial high, remaining multiplier}; each step adds and shifts right
  always_comb begin
    sum_c     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    product_c = {sum_c, prod_q[WIDTH-1:1]};
    done_c    = busy_q && (cnt_q == CNTW'(WIDTH - 1));
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    if (start) begin
      prod_d  = {{WIDTH{1'b0}}, b};
      mcand_d = a;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      prod_d = product_c;
      cnt_d  = cnt_q + CNTW'(1);
      if (done_c) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready on both sides; multiply is WIDTH cycles.
// Define ALU_FLAGS_EN to add the registered {neg, carry, zero} flags port.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    x,
`ifdef ALU_FLAGS_EN
  output logic [FLAGS_W-1:0]  flags,
`endif
  output logic [WIDTH-1:0]    y
);

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0]   res_x, res_y;
  logic [WIDTH:0]     sum_c;
  logic               accept, mul_start, mul_busy, mul_done_c;
  logic [2*WIDTH-1:0] mul_prod_c;
`ifdef ALU_FLAGS_EN
  logic [FLAGS_W-1:0] flags_q, flags_d, res_flags, mul_flags;
`endif

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start),
    .a         (a),
    .b         (b),
    .busy      (mul_busy),
    .done_c    (mul_done_c),
    .product_c (mul_prod_c)
  );

  assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle datapath; shifts by >= WIDTH naturally yield zero
  always_comb begin
    sum_c = {1'b0, a} + {1'b0, b};
    res_x = '0;
    res_y = '0;
    case (opcode)
      OP_ORR:          res_x = WIDTH'(|a);
      OP_ANDR:         res_x = WIDTH'(&a);
      OP_XORR:         res_x = WIDTH'(^a);
      OP_AND:          res_x = a & b;
      OP_OR:           res_x = a | b;
      OP_XOR:          res_x = a ^ b;
      OP_GT:           res_x = WIDTH'(a > b);
      OP_LT:           res_x = WIDTH'(a < b);
      OP_NOT, OP_NOT2: res_x = ~a;
      OP_EQ:           res_x = WIDTH'(a == b);
      OP_ADD: begin
        res_x = sum_c[WIDTH-1:0];
        res_y = WIDTH'(sum_c[WIDTH]);
      end
      OP_SUB: begin
        res_x = a - b;
        res_y = WIDTH'(a < b);
      end
      OP_SHR:          res_x = a >> b;
      OP_SHL:          res_x = a << b;
      default:         res_x = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  always_comb begin
    res_flags             = '0;
    res_flags[FLAG_NEG]   = res_x[WIDTH-1];
    res_flags[FLAG_CARRY] = ((opcode == OP_ADD) || (opcode == OP_SUB)) && res_y[0];
    res_flags[FLAG_ZERO]  = (res_x == '0);
    mul_flags             = '0;
    mul_flags[FLAG_NEG]   = mul_prod_c[WIDTH-1];
    mul_flags[FLAG_ZERO]  = (mul_prod_c[WIDTH-1:0] == '0);
  end
`endif

  // Control FSM: DONE with out_ready behaves like IDLE for a same-edge accept
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    x_d         = x_q;
    y_d         = y_q;
    mul_start   = 1'b0;
`ifdef ALU_FLAGS_EN
    flags_d     = flags_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
        if (accept) begin
          if (opcode == OP_MUL) begin
            mul_start   = 1'b1;
            state_d     = S_MUL;
            out_valid_d = 1'b0;
          end else begin
            x_d         = res_x;
            y_d         = res_y;
            state_d     = S_DONE;
            out_valid_d = 1'b1;
`ifdef ALU_FLAGS_EN
            flags_d     = res_flags;
`endif
          end
        end
      end
      S_MUL: begin
        if (mul_busy && mul_done_c) begin
          x_d         = mul_prod_c[WIDTH-1:0];
          y_d         = mul_prod_c[2*WIDTH-1:WIDTH];
          state_d     = S_DONE;
          out_valid_d = 1'b1;
`ifdef ALU_FLAGS_EN
          flags_d     = mul_flags;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
`ifdef ALU_FLAGS_EN
      flags_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
`ifdef ALU_FLAGS_EN
      flags_q     <= flags_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign x         = x_q;
  assign y         = y_q;
`ifdef ALU_FLAGS_EN
  assign flags     = flags_q;
`endif

endmodule
